// File: rtl/brew_timer_pkg.sv
// Shared types and widths for the coffee machine brew timer.
package coffee_pkg;

   localparam int unsigned CNT_W  = 7;
   localparam int unsigned SZ_W   = 2;
   localparam int unsigned BCD_W  = 4;
   localparam int unsigned SEC_MAX = 99;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PREHEAT = 3'd1,
      BREW    = 3'd2,
      PAUSED  = 3'd3,
      DONE    = 3'd4
   } state_t;

   typedef enum logic [SZ_W-1:0] {
      SZ_NONE  = 2'd0,
      SZ_SMALL = 2'd1,
      SZ_MED   = 2'd2,
      SZ_LARGE = 2'd3
   } size_t;

   // Brew duration for a cup-size code; zero for "no cup".
   function automatic logic [CNT_W-1:0] size_secs(input logic [SZ_W-1:0] sz,
                                                  input int unsigned s_sec,
                                                  input int unsigned m_sec,
                                                  input int unsigned l_sec);
      case (sz)
         SZ_SMALL: return CNT_W'(s_sec);
         SZ_MED:   return CNT_W'(m_sec);
         SZ_LARGE: return CNT_W'(l_sec);
         default:  return '0;
      endcase
   endfunction

   // True when a seconds value fits the two-digit display.
   function automatic bit sec_ok(input int unsigned v);
      return (v >= 1) && (v <= SEC_MAX);
   endfunction

endpackage

// File: rtl/brew_timer_if.sv
// Control and status bundle between the machine controller and the brew timer.
interface brew_timer_if;

   logic                               start;
   logic [coffee_pkg::SZ_W-1:0]        size;
   logic                               pause;
   logic                               cancel;
   logic [coffee_pkg::CNT_W-1:0]       secs_left;
   logic [coffee_pkg::BCD_W-1:0]       bcd_tens;
   logic [coffee_pkg::BCD_W-1:0]       bcd_ones;
   logic                               brewing;
   logic                               done;
   logic                               done_pulse;
   logic                               heater_on;

   modport master (
      output start, size, pause, cancel,
      input  secs_left, bcd_tens, bcd_ones, brewing, done, done_pulse, heater_on
   );

   modport slave (
      input  start, size, pause, cancel,
      output secs_left, bcd_tens, bcd_ones, brewing, done, done_pulse, heater_on
   );

endinterface

// File: rtl/brew_timer_tick_sync.sv
// Resynchronises the 1 Hz square wave and emits a one-cycle tick per rising edge.
module tick_sync (
   input  logic clk_100MHz,
   input  logic reset_n,
   input  logic clk_1Hz,
   output logic tick
);

   logic s1, s2, s3;

   // Two-flop synchroniser followed by an edge-history flop.
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= clk_1Hz;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign tick = s2 & ~s3;

endmodule

// File: rtl/brew_timer.sv
// Brew-cycle countdown with BCD display outputs.
// Optional preheat phase compiled in with macro BREW_PREHEAT_EN.
module brew_timer
   import coffee_pkg::*;
#(
   parameter int unsigned SMALL_SEC   = 30,
   parameter int unsigned MED_SEC     = 45,
   parameter int unsigned LARGE_SEC   = 60,
   parameter int unsigned PREHEAT_SEC = 5
) (
   input  logic          clk_100MHz,
   input  logic          reset_n,
   input  logic          clk_1Hz,
   brew_timer_if.slave   bus
);

   localparam bit PARAMS_OK = sec_ok(SMALL_SEC) && sec_ok(MED_SEC) &&
                              sec_ok(LARGE_SEC) && sec_ok(PREHEAT_SEC);

   state_t             state;
   logic               tick;
   logic [CNT_W-1:0]   secs_q;
   logic [BCD_W-1:0]   tens_q, ones_q;
   logic               brewing_q, done_q, pulse_q, heater_q;
   logic               start_ok;
`ifdef BREW_PREHEAT_EN
   logic [SZ_W-1:0]    size_q;
`endif

   tick_sync u_sync (
      .clk_100MHz (clk_100MHz),
      .reset_n    (reset_n),
      .clk_1Hz    (clk_1Hz),
      .tick       (tick)
   );

   assign start_ok = bus.start && (bus.size != SZ_NONE);

   // Countdown FSM; status outputs are set alongside each transition.
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         secs_q    <= '0;
         brewing_q <= 1'b0;
         done_q    <= 1'b0;
         pulse_q   <= 1'b0;
         heater_q  <= 1'b0;
`ifdef BREW_PREHEAT_EN
         size_q    <= SZ_NONE;
`endif
      end else begin
         pulse_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if ((state == DONE) && bus.cancel) begin
                  state  <= IDLE;
                  done_q <= 1'b0;
                  secs_q <= '0;
               end else if (start_ok) begin
                  done_q <= 1'b0;
`ifdef BREW_PREHEAT_EN
                  state    <= PREHEAT;
                  heater_q <= 1'b1;
                  secs_q   <= CNT_W'(PREHEAT_SEC);
                  size_q   <= bus.size;
`else
                  state     <= BREW;
                  brewing_q <= 1'b1;
                  secs_q    <= size_secs(bus.size, SMALL_SEC, MED_SEC, LARGE_SEC);
`endif
               end
            end
`ifdef BREW_PREHEAT_EN
            PREHEAT: begin
               if (bus.cancel) begin
                  state    <= IDLE;
                  heater_q <= 1'b0;
                  secs_q   <= '0;
               end else if (tick) begin
                  if (secs_q > CNT_W'(1)) begin
                     secs_q <= secs_q - CNT_W'(1);
                  end else begin
                     state     <= BREW;
                     heater_q  <= 1'b0;
                     brewing_q <= 1'b1;
                     secs_q    <= size_secs(size_q, SMALL_SEC, MED_SEC, LARGE_SEC);
                  end
               end
            end
`endif
            BREW: begin
               if (bus.cancel) begin
                  state     <= IDLE;
                  brewing_q <= 1'b0;
                  secs_q    <= '0;
               end else if (bus.pause) begin
                  state     <= PAUSED;
                  brewing_q <= 1'b0;
               end else if (tick) begin
                  if (secs_q > CNT_W'(1)) begin
                     secs_q <= secs_q - CNT_W'(1);
                  end else begin
                     state     <= DONE;
                     secs_q    <= '0;
                     brewing_q <= 1'b0;
                     done_q    <= 1'b1;
                     pulse_q   <= 1'b1;
                  end
               end
            end
            PAUSED: begin
               if (bus.cancel) begin
                  state  <= IDLE;
                  secs_q <= '0;
               end else if (!bus.pause) begin
                  state     <= BREW;
                  brewing_q <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               secs_q    <= '0;
               brewing_q <= 1'b0;
               done_q    <= 1'b0;
               heater_q  <= 1'b0;
            end
         endcase
      end
   end

   // Display digits trail secs_left by one cycle.
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= BCD_W'(secs_q / CNT_W'(10));
         ones_q <= BCD_W'(secs_q % CNT_W'(10));
      end
   end

   // Flag out-of-range durations during simulation.
   always_ff @(posedge clk_100MHz) begin
      if (reset_n) begin
         assert (PARAMS_OK)
            else $error("brew_timer: duration parameter outside 1..99");
      end
   end

   assign bus.secs_left  = secs_q;
   assign bus.bcd_tens   = tens_q;
   assign bus.bcd_ones   = ones_q;
   assign bus.brewing    = brewing_q;
   assign bus.done       = done_q;
   assign bus.done_pulse = pulse_q;
   assign bus.heater_on  = heater_q;

endmodule

// File: tb/tb_brew_timer.sv
// Self-checking bench for brew_timer; clk_1Hz is driven with a 200-cycle period.
module tb_brew_timer;
   import coffee_pkg::*;

   logic clk_100MHz = 1'b0;
   logic reset_n    = 1'b0;
   logic clk_1Hz    = 1'b0;

   brew_timer_if bus ();

   brew_timer dut (
      .clk_100MHz (clk_100MHz),
      .reset_n    (reset_n),
      .clk_1Hz    (clk_1Hz),
      .bus        (bus.slave)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   typedef enum {OP_START, OP_TICKS, OP_PAUSE_TICKS, OP_UNPAUSE, OP_CANCEL, OP_CANCEL_TICK} op_e;

   typedef struct {
      op_e        op;
      logic [1:0] sz;
      int         n;
      int         e_secs;
      int         e_tens;
      int         e_ones;
      logic       e_brew;
      logic       e_done;
      int         e_pulses;
   } vec_t;

   typedef struct {
      string name;
      int    secs;
      int    tens;
      int    ones;
      logic  brew;
      logic  done;
      logic  heat;
      int    pulses;
   } exp_t;

   localparam int NV = 21;
   vec_t vt [NV];
   exp_t sb [$];
   int   n_vec     = 0;
   int   n_bad     = 0;
   int   pulse_cnt = 0;

   // Count done_pulse cycles since the last start request.
   always @(negedge clk_100MHz) if (bus.done_pulse === 1'b1) pulse_cnt++;

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_100MHz);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         clk_1Hz = 1'b1;
         wait_cyc(100);
         clk_1Hz = 1'b0;
         wait_cyc(100);
      end
   endtask

   task automatic push_exp(input string name, input int secs, input int tens, input int ones,
                           input logic brew, input logic done, input logic heat, input int pulses);
      exp_t e;
      e.name = name; e.secs = secs; e.tens = tens; e.ones = ones;
      e.brew = brew; e.done = done; e.heat = heat; e.pulses = pulses;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      if (sb.size() == 0) begin
         n_vec++; n_bad++;
         $display("FAIL scoreboard_empty: got no expected entry, want one");
         return;
      end
      e = sb.pop_front();
      n_vec++;
      if (bus.secs_left !== CNT_W'(e.secs) || bus.bcd_tens !== BCD_W'(e.tens) ||
          bus.bcd_ones !== BCD_W'(e.ones) || bus.brewing !== e.brew ||
          bus.done !== e.done || bus.heater_on !== e.heat || pulse_cnt != e.pulses) begin
         n_bad++;
         $display("FAIL %s: got secs=%0d tens=%0d ones=%0d brew=%b done=%b heat=%b pulses=%0d, want secs=%0d tens=%0d ones=%0d brew=%b done=%b heat=%b pulses=%0d",
                  e.name, bus.secs_left, bus.bcd_tens, bus.bcd_ones, bus.brewing, bus.done,
                  bus.heater_on, pulse_cnt, e.secs, e.tens, e.ones, e.brew, e.done, e.heat, e.pulses);
      end
   endtask

   task automatic do_start(input logic [1:0] sz);
      pulse_cnt  = 0;
      bus.start  = 1'b1;
      bus.size   = sz;
      wait_cyc(1);
      bus.start  = 1'b0;
`ifdef BREW_PREHEAT_EN
      if (sz != 2'd0) begin
         push_exp("preheat_load", 5, 0, 5, 1'b0, 1'b0, 1'b1, 0);
         wait_cyc(4);
         check_pop();
         ticks(4);
         push_exp("preheat_last", 1, 0, 1, 1'b0, 1'b0, 1'b1, 0);
         check_pop();
         ticks(1);
      end
`endif
   endtask

   function automatic vec_t mk(input op_e op, input logic [1:0] sz, input int n, input int s,
                               input int t, input int o, input logic b, input logic d, input int p);
      vec_t v;
      v.op = op; v.sz = sz; v.n = n; v.e_secs = s; v.e_tens = t; v.e_ones = o;
      v.e_brew = b; v.e_done = d; v.e_pulses = p;
      return v;
   endfunction

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      vt[0]  = mk(OP_START,       2'd1,  0, 30, 3, 0, 1'b1, 1'b0, 0);
      vt[1]  = mk(OP_TICKS,       2'd0, 29,  1, 0, 1, 1'b1, 1'b0, 0);
      vt[2]  = mk(OP_TICKS,       2'd0,  1,  0, 0, 0, 1'b0, 1'b1, 1);
      vt[3]  = mk(OP_START,       2'd2,  0, 45, 4, 5, 1'b1, 1'b0, 0);
      vt[4]  = mk(OP_CANCEL,      2'd0,  0,  0, 0, 0, 1'b0, 1'b0, 0);
      vt[5]  = mk(OP_START,       2'd3,  0, 60, 6, 0, 1'b1, 1'b0, 0);
      vt[6]  = mk(OP_TICKS,       2'd0,  1, 59, 5, 9, 1'b1, 1'b0, 0);
      vt[7]  = mk(OP_TICKS,       2'd0, 10, 49, 4, 9, 1'b1, 1'b0, 0);
      vt[8]  = mk(OP_CANCEL_TICK, 2'd0,  0,  0, 0, 0, 1'b0, 1'b0, 0);
      vt[9]  = mk(OP_START,       2'd0,  0,  0, 0, 0, 1'b0, 1'b0, 0);
      vt[10] = mk(OP_TICKS,       2'd0,  2,  0, 0, 0, 1'b0, 1'b0, 0);
      vt[11] = mk(OP_START,       2'd2,  0, 45, 4, 5, 1'b1, 1'b0, 0);
      vt[12] = mk(OP_TICKS,       2'd0,  5, 40, 4, 0, 1'b1, 1'b0, 0);
      vt[13] = mk(OP_PAUSE_TICKS, 2'd0,  5, 40, 4, 0, 1'b0, 1'b0, 0);
      vt[14] = mk(OP_UNPAUSE,     2'd0,  0, 40, 4, 0, 1'b1, 1'b0, 0);
      vt[15] = mk(OP_TICKS,       2'd0,  1, 39, 3, 9, 1'b1, 1'b0, 0);
      vt[16] = mk(OP_PAUSE_TICKS, 2'd0,  1, 39, 3, 9, 1'b0, 1'b0, 0);
      vt[17] = mk(OP_CANCEL,      2'd0,  0,  0, 0, 0, 1'b0, 1'b0, 0);
      vt[18] = mk(OP_UNPAUSE,     2'd0,  0,  0, 0, 0, 1'b0, 1'b0, 0);
      vt[19] = mk(OP_START,       2'd1,  0, 30, 3, 0, 1'b1, 1'b0, 0);
      vt[20] = mk(OP_TICKS,       2'd0, 13, 17, 1, 7, 1'b1, 1'b0, 0);

      bus.start = 1'b0; bus.size = 2'd0; bus.pause = 1'b0; bus.cancel = 1'b0;
      wait_cyc(3);
      push_exp("reset_state", 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      check_pop();
      reset_n = 1'b1;
      wait_cyc(3);

      for (int i = 0; i < NV; i++) begin
         v = vt[i];
         push_exp($sformatf("vec%0d", i), v.e_secs, v.e_tens, v.e_ones,
                  v.e_brew, v.e_done, 1'b0, v.e_pulses);
         case (v.op)
            OP_START:       do_start(v.sz);
            OP_TICKS:       ticks(v.n);
            OP_PAUSE_TICKS: begin bus.pause = 1'b1; wait_cyc(2); ticks(v.n); end
            OP_UNPAUSE:     bus.pause = 1'b0;
            OP_CANCEL:      begin bus.cancel = 1'b1; wait_cyc(1); bus.cancel = 1'b0; end
            OP_CANCEL_TICK: begin
               // Tick reaches the FSM on the third rising clock edge after clk_1Hz rises.
               clk_1Hz = 1'b1;
               wait_cyc(2);
               bus.cancel = 1'b1;
               wait_cyc(1);
               bus.cancel = 1'b0;
               wait_cyc(97);
               clk_1Hz = 1'b0;
               wait_cyc(100);
            end
            default: ;
         endcase
         wait_cyc(4);
         check_pop();
      end

      // Asynchronous reset in the middle of BREW at 17 seconds.
      @(posedge clk_100MHz);
      #2 reset_n = 1'b0;
      push_exp("async_reset", 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      #1 check_pop();
      wait_cyc(2);
      reset_n = 1'b1;
      push_exp("post_reset_ticks", 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      ticks(2);
      check_pop();

      // Fresh run to completion after reset, then a restart from DONE.
      push_exp("post_reset_start", 30, 3, 0, 1'b1, 1'b0, 1'b0, 0);
      do_start(2'd1);
      wait_cyc(4);
      check_pop();
      push_exp("post_reset_done", 0, 0, 0, 1'b0, 1'b1, 1'b0, 1);
      ticks(30);
      check_pop();
      push_exp("done_hold", 0, 0, 0, 1'b0, 1'b1, 1'b0, 1);
      ticks(2);
      check_pop();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/brew_timer.md
Name: brew_timer

Overview:
- Brew-cycle countdown for the coffee machine simulator, directly downstream of the 1 Hz generator.
- Synchronises the generator's 1 Hz square wave into a one-cycle tick on clk_100MHz and counts down a cup-size-dependent brew time.
- Drives the BCD seconds display, a pump/brewing indicator and a done indication.

Parameters:
- SMALL_SEC, 30, brew seconds for size code 1 (legal range 1..99)
- MED_SEC, 45, brew seconds for size code 2 (legal range 1..99)
- LARGE_SEC, 60, brew seconds for size code 3 (legal range 1..99)
- PREHEAT_SEC, 5, preheat seconds; used only when the optional feature is compiled in (legal range 1..99)

Ports:
- clk_100MHz  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- clk_1Hz  in  1  1 Hz square wave from the generator; asynchronous to this block's logic and resynchronised internally.
- start  in  1  one-cycle start request, synchronous.
- size  in  2  cup size: 0 = none, 1 = small, 2 = medium, 3 = large.
- pause  in  1  level; while high, countdown is held.
- cancel  in  1  one-cycle abort/acknowledge.
- secs_left  out  7  seconds remaining, binary.
- bcd_tens  out  4  tens digit of secs_left.
- bcd_ones  out  4  ones digit of secs_left.
- brewing  out  1  high in BREW state (pump on).
- done  out  1  high in DONE state.
- done_pulse  out  1  one-cycle pulse on entry to DONE.
- heater_on  out  1  high in PREHEAT (feature only; tied 0 otherwise).

Behaviour:
- Reset: asynchronous on reset_n low.
  - State returns to IDLE; all outputs go to 0; sync flops clear.
- Tick:
  - Three flops s1 → s2 → s3 on clk_1Hz; tick = s2 & ~s3.
  - Tick is high for exactly 1 cycle per rising edge of clk_1Hz.
  - Tick appears 2–3 clk_100MHz cycles after that edge.
- States: IDLE, BREW, PAUSED, DONE (plus PREHEAT with the optional feature).
- IDLE:
  - secs_left = 0.
  - start with size ≠ 0: load the duration for that size and go to BREW.
  - start with size = 0: ignored; stay in IDLE.
- BREW:
  - cancel → IDLE, secs_left = 0.
  - Else pause → PAUSED.
  - Else tick with secs_left > 1: decrement.
  - Else tick with secs_left = 1: secs_left = 0, go to DONE, done_pulse = 1 for that cycle.
- PAUSED:
  - cancel → IDLE.
  - pause low → BREW.
  - Ticks are discarded; secs_left is frozen.
- DONE:
  - cancel → IDLE.
  - start with size ≠ 0: reload the duration and go to BREW.
  - Otherwise stay in DONE.
- Priority within one cycle: cancel > pause > tick.
- start is ignored in BREW, PAUSED and PREHEAT.
- A tick coinciding with the load cycle is ignored. The first decrement occurs on the next tick, so the first second may be partial; this is accepted.
- Outputs are registered.
  - secs_left updates in the cycle after the tick.
  - bcd_tens/bcd_ones are registered from secs_left with +1 cycle latency: tens = secs_left / 10, ones = secs_left mod 10, both for values 0..99.
- brewing and done are decoded from state.
- Parameter values outside 1..99 are a configuration error; a simulation assertion flags them.

Optional Feature:
- Macro: BREW_PREHEAT_EN.
- With the macro:
  - start (size ≠ 0) from IDLE or DONE enters PREHEAT and loads PREHEAT_SEC.
  - heater_on = 1 in PREHEAT.
  - Tick decrements the count. At 1, the next tick loads the size duration and enters BREW; done_pulse is not asserted.
  - cancel → IDLE. pause is ignored in PREHEAT.
  - The latched size is held in a 2-bit register captured at start.
- Without the macro: no PREHEAT state, no size register, and heater_on is tied 0.

Decomposition:
- Package coffee_pkg holds:
  - state enum: IDLE, PREHEAT, BREW, PAUSED, DONE;
  - size codes SZ_NONE/SZ_SMALL/SZ_MED/SZ_LARGE;
  - CNT_W = 7.
- Sub-module tick_sync: 3-flop synchroniser plus rising-edge detector. Ports: clk_100MHz, reset_n, clk_1Hz, tick.

Test Plan (bench drives clk_1Hz with a 200-cycle period for speed):
- Reset mid-BREW at secs_left = 17 → all outputs 0 immediately (asynchronous); after release, state is IDLE and ticks are ignored.
- start with size = 1 → secs_left = 30 and brewing = 1. After 29 ticks secs_left = 1. The 30th tick gives secs_left = 0, done = 1, done_pulse high for exactly 1 cycle, and bcd digits 0/0.
- start with size = 3; check digits tens = 6/ones = 0, then 5/9 after one tick, then 4/9 after eleven ticks (secs_left = 49).
- size = 2, pause high for 5 ticks at secs_left = 40 → secs_left stays 40. After pause falls, the next tick gives 39.
- cancel and tick in the same cycle in BREW → IDLE with secs_left = 0 and no done_pulse. start with size = 0 in IDLE → no change.
- BREW_PREHEAT_EN, size = 1 → heater_on = 1 for 5 ticks, then brewing = 1 with secs_left = 30. done is asserted 35 ticks after start.
